apu_mult_dispatch: RTL and testbench

Initiator-side dispatcher for the shared FP multiplier on the APU interface. It accepts multiply requests from NCORES cores and arbitrates them round-robin. It drives the multiplier unit's En/OpA/OpB/Tag/Rnd inputs, with the core index carried as the tag. Results returned by the unit are held in a per-core slot until that core accepts them.

---
 rtl/apu_cluster_package.sv | 15 +
 rtl/apu_rr_arbiter.sv | 40 ++++
 rtl/apu_mult_dispatch.sv | 147 ++++++++++++++
 tb/tb_apu_mult_dispatch.sv | 388 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/apu_cluster_package.sv
// Shared constants and types for the APU cluster: FP datapath widths and
// the per-core result slot state used by the multiplier dispatcher.
package apu_cluster_package;

    localparam int FP_WIDTH      = 32;
    localparam int NDSFLAGS_MULT = 3;
    localparam int NUSFLAGS_MULT = 5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } slot_state_t;

endpackage

// File: rtl/apu_rr_arbiter.sv
// Combinational round-robin arbiter: the first asserted request at or after
// ptr_i (wrapping) wins; grant is one-hot or zero.
module apu_rr_arbiter #(
    parameter int N = 4
) (
    input  logic [N-1:0]         req_i,
    input  logic [$clog2(N)-1:0] ptr_i,
    output logic [N-1:0]         gnt_o,
    output logic [$clog2(N)-1:0] gnt_idx_o
);

    localparam int IDX_W = $clog2(N);
    localparam int SUM_W = IDX_W + 1;

    logic [SUM_W-1:0] sum;
    logic [IDX_W-1:0] cand;
    logic             found;

    always_comb begin
        gnt_o     = '0;
        gnt_idx_o = '0;
        found     = 1'b0;
        sum       = '0;
        cand      = '0;
        for (int i = 0; i < N; i++) begin
            // ptr_i < N and i < N, so one conditional subtract wraps the sum
            sum = SUM_W'(ptr_i) + SUM_W'(i);
            if (sum >= SUM_W'(N)) begin
                sum = sum - SUM_W'(N);
            end
            cand = sum[IDX_W-1:0];
            if (!found && req_i[cand]) begin
                gnt_o[cand] = 1'b1;
                gnt_idx_o   = cand;
                found       = 1'b1;
            end
        end
    end

endmodule

// File: rtl/apu_mult_dispatch.sv
// Initiator-side dispatcher for the shared FP multiplier: round-robin issue
// from NCORES cores, core index as unit tag, per-core result slots.
module apu_mult_dispatch
    import apu_cluster_package::*;
#(
    parameter int NCORES     = 4,
    parameter int TAG_WIDTH  = $clog2(NCORES),
    parameter int RND_WIDTH  = NDSFLAGS_MULT,
    parameter int STAT_WIDTH = NUSFLAGS_MULT
) (
    input  logic                                 clk_i,
    input  logic                                 rst_i,
    // Handshakes: a transfer occurs in any cycle where valid and ready are
    // both high at the rising edge; ready may depend combinationally on valid.
    input  logic [NCORES-1:0]                    req_valid_i,
    output logic [NCORES-1:0]                    req_ready_o,
    input  logic [NCORES-1:0][FP_WIDTH-1:0]      req_opa_i,
    input  logic [NCORES-1:0][FP_WIDTH-1:0]      req_opb_i,
    input  logic [NCORES-1:0][RND_WIDTH-1:0]     req_rnd_i,
    output logic [NCORES-1:0]                    resp_valid_o,
    input  logic [NCORES-1:0]                    resp_ready_i,
    output logic [NCORES-1:0][FP_WIDTH-1:0]      resp_res_o,
    output logic [NCORES-1:0][STAT_WIDTH-1:0]    resp_status_o,
    output logic                                 En_o,
    output logic [FP_WIDTH-1:0]                  OpA_o,
    output logic [FP_WIDTH-1:0]                  OpB_o,
    output logic [TAG_WIDTH-1:0]                 Tag_o,
    output logic [RND_WIDTH-1:0]                 Rnd_o,
    input  logic                                 Ready_i,
    input  logic                                 Valid_i,
    input  logic [FP_WIDTH-1:0]                  Res_i,
    input  logic [STAT_WIDTH-1:0]                Status_i,
    input  logic [TAG_WIDTH-1:0]                 Tag_i,
    output logic                                 Ack_o,
    output logic                                 busy_o,
    output logic                                 err_o,
    output slot_state_t [NCORES-1:0]             slot_state_o,
    output logic [TAG_WIDTH-1:0]                 rr_ptr_o
);

    logic [NCORES-1:0]    slot_idle;
    logic [NCORES-1:0]    busy_hit;
    logic [NCORES-1:0]    eligible;
    logic [NCORES-1:0]    gnt;
    logic [TAG_WIDTH-1:0] gnt_idx;
    logic                 any_gnt;
    logic [TAG_WIDTH-1:0] rr_ptr_q;
    logic                 err_q;

    assign eligible = req_valid_i & slot_idle & {NCORES{Ready_i & ~rst_i}};

    apu_rr_arbiter #(
        .N(NCORES)
    ) u_arb (
        .req_i     (eligible),
        .ptr_i     (rr_ptr_q),
        .gnt_o     (gnt),
        .gnt_idx_o (gnt_idx)
    );

    assign any_gnt     = |gnt;
    assign req_ready_o = gnt;

    for (genvar k = 0; k < NCORES; k++) begin : gen_slot
        slot_state_t          state_q;
        slot_state_t          state_d;
        logic [FP_WIDTH-1:0]   res_q;
        logic [STAT_WIDTH-1:0] status_q;

        // A result only belongs to slot k if it is waiting for one
        assign busy_hit[k] = Valid_i && (state_q == BUSY) && (Tag_i == TAG_WIDTH'(k));

        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                state_q <= IDLE;
            end else begin
                state_q <= state_d;
            end
        end

        always_comb begin
            state_d = state_q;
            case (state_q)
                IDLE:    if (gnt[k])          state_d = BUSY;
                BUSY:    if (busy_hit[k])     state_d = DONE;
                DONE:    if (resp_ready_i[k]) state_d = IDLE;
                default:                      state_d = IDLE;
            endcase
        end

        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                res_q    <= '0;
                status_q <= '0;
            end else if (busy_hit[k]) begin
                res_q    <= Res_i;
                status_q <= Status_i;
            end
        end

        assign slot_idle[k]     = (state_q == IDLE);
        assign resp_valid_o[k]  = (state_q == DONE);
        assign resp_res_o[k]    = res_q;
        assign resp_status_o[k] = status_q;
        assign slot_state_o[k]  = state_q;
    end

    // Issue register: operands are zeroed whenever nothing is issued
    always_ff @(posedge clk_i) begin
        if (rst_i || !any_gnt) begin
            En_o  <= 1'b0;
            OpA_o <= '0;
            OpB_o <= '0;
            Tag_o <= '0;
            Rnd_o <= '0;
        end else begin
            En_o  <= 1'b1;
            OpA_o <= req_opa_i[gnt_idx];
            OpB_o <= req_opb_i[gnt_idx];
            Tag_o <= gnt_idx;
            Rnd_o <= req_rnd_i[gnt_idx];
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rr_ptr_q <= '0;
        end else if (any_gnt) begin
            rr_ptr_q <= (gnt_idx == TAG_WIDTH'(NCORES - 1)) ? '0 : gnt_idx + TAG_WIDTH'(1);
        end
    end

    // Unmatched results (bad tag or slot not waiting) are dropped and flagged
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            err_q <= 1'b0;
        end else if (Valid_i && !(|busy_hit)) begin
            err_q <= 1'b1;
        end
    end

    assign err_o    = err_q;
    assign busy_o   = ~&slot_idle;
    assign rr_ptr_o = rr_ptr_q;
    assign Ack_o    = 1'b1;

endmodule

// File: tb/tb_apu_mult_dispatch.sv
// Directed bench for apu_mult_dispatch with a behavioural multiplier unit of
// configurable latency and a result-injection port for protocol errors.
module tb_apu_mult_dispatch;
    import apu_cluster_package::*;

    localparam int NC = 4;

    logic                      clk;
    logic                      rst;
    logic [NC-1:0]             req_valid;
    logic [NC-1:0]             req_ready;
    logic [NC-1:0][31:0]       req_opa;
    logic [NC-1:0][31:0]       req_opb;
    logic [NC-1:0][2:0]        req_rnd;
    logic [NC-1:0]             resp_valid;
    logic [NC-1:0]             resp_ready;
    logic [NC-1:0][31:0]       resp_res;
    logic [NC-1:0][4:0]        resp_status;
    logic                      en;
    logic [31:0]               opa;
    logic [31:0]               opb;
    logic [1:0]                tag;
    logic [2:0]                rnd;
    logic                      unit_ready;
    logic                      unit_valid;
    logic [31:0]               unit_res_w;
    logic [4:0]                unit_status;
    logic [1:0]                unit_tag;
    logic                      ack;
    logic                      busy;
    logic                      err;
    slot_state_t [NC-1:0]      slot_state;
    logic [1:0]                rr_ptr;

    apu_mult_dispatch #(.NCORES(NC)) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .req_valid_i   (req_valid),
        .req_ready_o   (req_ready),
        .req_opa_i     (req_opa),
        .req_opb_i     (req_opb),
        .req_rnd_i     (req_rnd),
        .resp_valid_o  (resp_valid),
        .resp_ready_i  (resp_ready),
        .resp_res_o    (resp_res),
        .resp_status_o (resp_status),
        .En_o          (en),
        .OpA_o         (opa),
        .OpB_o         (opb),
        .Tag_o         (tag),
        .Rnd_o         (rnd),
        .Ready_i       (unit_ready),
        .Valid_i       (unit_valid),
        .Res_i         (unit_res_w),
        .Status_i      (unit_status),
        .Tag_i         (unit_tag),
        .Ack_o         (ack),
        .busy_o        (busy),
        .err_o         (err),
        .slot_state_o  (slot_state),
        .rr_ptr_o      (rr_ptr)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    // ---------------- behavioural multiplier unit ----------------
    // Stand-in arithmetic: 1.0 * x returns x, everything else is a fixed mix.
    function automatic logic [31:0] unit_res(input logic [31:0] a, input logic [31:0] b);
        return a ^ b ^ 32'h3F80_0000;
    endfunction

    function automatic logic [4:0] unit_st(input logic [2:0] r);
        return {2'b10, r};
    endfunction

    int          unit_lat = 0;
    logic        inj_v;
    logic [1:0]  inj_tag;
    logic        pv [4];
    logic [31:0] pr [4];
    logic [1:0]  pt [4];
    logic [4:0]  ps [4];
    logic        mv;
    logic [31:0] mr;
    logic [1:0]  mt;
    logic [4:0]  ms;

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) pv[i] <= 1'b0;
        end else begin
            pv[0] <= en;
            pr[0] <= unit_res(opa, opb);
            pt[0] <= tag;
            ps[0] <= unit_st(rnd);
            for (int i = 1; i < 4; i++) begin
                pv[i] <= pv[i-1];
                pr[i] <= pr[i-1];
                pt[i] <= pt[i-1];
                ps[i] <= ps[i-1];
            end
        end
    end

    always_comb begin
        if (unit_lat == 0) begin
            mv = en;
            mr = unit_res(opa, opb);
            mt = tag;
            ms = unit_st(rnd);
        end else begin
            mv = pv[unit_lat-1];
            mr = pr[unit_lat-1];
            mt = pt[unit_lat-1];
            ms = ps[unit_lat-1];
        end
        unit_valid  = mv | inj_v;
        unit_tag    = inj_v ? inj_tag : mt;
        unit_res_w  = mr;
        unit_status = ms;
    end

    // ---------------- scoreboard / monitor ----------------
    logic [1:0]  exp_q[$];
    int          got_q[$];
    logic [31:0] exp_res [NC];
    logic [4:0]  exp_st  [NC];
    logic [NC-1:0] outstanding;

    always @(negedge clk) begin
        if (rst) begin
            outstanding <= '0;
        end else begin
            for (int k = 0; k < NC; k++) begin
                if (req_valid[k] && req_ready[k]) begin
                    check_eq("no_reissue", 64'(outstanding[k]), 64'd0);
                    outstanding[k] <= 1'b1;
                    exp_res[k] <= unit_res(req_opa[k], req_opb[k]);
                    exp_st[k]  <= unit_st(req_rnd[k]);
                    got_q.push_back(k);
                end
                if (resp_valid[k] && resp_ready[k]) begin
                    check_eq("resp_res", 64'(resp_res[k]), 64'(exp_res[k]));
                    check_eq("resp_status", 64'(resp_status[k]), 64'(exp_st[k]));
                    outstanding[k] <= 1'b0;
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_req(input int k, input logic [31:0] a, input logic [31:0] b,
                             input logic [2:0] r);
        req_opa[k]   = a;
        req_opb[k]   = b;
        req_rnd[k]   = r;
        req_valid[k] = 1'b1;
    endtask

    task automatic do_reset();
        rst        = 1'b1;
        req_valid  = '0;
        inj_v      = 1'b0;
        unit_ready = 1'b1;
        resp_ready = '1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic wait_idle();
        for (int c = 0; c < 50 && busy; c++) tick();
        check_eq("idle_timeout", 64'(busy), 64'd0);
    endtask

    function automatic int count_grants(input int k);
        int n = 0;
        foreach (got_q[i]) if (got_q[i] == k) n++;
        return n;
    endfunction

    // ---------------- directed tests ----------------
    initial begin
        int lat;
        rst        = 1'b1;
        req_valid  = '0;
        req_opa    = '0;
        req_opb    = '0;
        req_rnd    = '0;
        resp_ready = '1;
        unit_ready = 1'b1;
        inj_v      = 1'b0;
        inj_tag    = '0;
        tick();
        tick();

        // reset values
        req_valid = '1;
        #1;
        check_eq("rst_req_ready", 64'(req_ready), 64'd0);
        check_eq("rst_en", 64'(en), 64'd0);
        check_eq("rst_opa", 64'(opa), 64'd0);
        check_eq("rst_tag", 64'(tag), 64'd0);
        check_eq("rst_resp_valid", 64'(resp_valid), 64'd0);
        check_eq("rst_resp_res0", 64'(resp_res[0]), 64'd0);
        check_eq("rst_err", 64'(err), 64'd0);
        check_eq("rst_busy", 64'(busy), 64'd0);
        check_eq("rst_rr_ptr", 64'(rr_ptr), 64'd0);
        check_eq("ack_tied", 64'(ack), 64'd1);
        req_valid = '0;

        // single op, L=0: core 1, 1.0 * 2.0
        do_reset();
        resp_ready = '0;
        drive_req(1, 32'h3F80_0000, 32'h4000_0000, 3'd0);
        #1;
        check_eq("single_ready", 64'(req_ready), 64'b0010);
        tick();
        req_valid = '0;
        check_eq("single_en", 64'(en), 64'd1);
        check_eq("single_tag", 64'(tag), 64'd1);
        check_eq("single_opa", 64'(opa), 64'h3F80_0000);
        check_eq("single_opb", 64'(opb), 64'h4000_0000);
        tick();
        check_eq("single_resp_valid", 64'(resp_valid), 64'b0010);
        check_eq("single_res", 64'(resp_res[1]), 64'h4000_0000);
        check_eq("single_status", 64'(resp_status[1]), 64'h10);
        check_eq("single_en_clr", 64'(en), 64'd0);
        check_eq("single_opa_clr", 64'(opa), 64'd0);
        tick();
        check_eq("single_hold", 64'(resp_valid), 64'b0010);
        resp_ready = '1;
        tick();
        check_eq("single_released", 64'(resp_valid), 64'd0);
        check_eq("single_idle", 64'(busy), 64'd0);
        drive_req(1, 32'h4000_0000, 32'h3F80_0000, 3'd2);
        #1;
        check_eq("single_reaccept", 64'(req_ready), 64'b0010);
        tick();
        req_valid = '0;
        wait_idle();

        // fairness: all cores request continuously
        do_reset();
        got_q.delete();
        for (int k = 0; k < NC; k++)
            drive_req(k, 32'h3F80_0000 + 32'(k << 20), 32'h4040_0000 + 32'(k), 3'(k));
        for (int c = 0; c < 40 && got_q.size() < 8; c++) tick();
        req_valid = '0;
        exp_q = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3};
        check_eq("fair_count", 64'(got_q.size() >= 8), 64'd1);
        for (int i = 0; i < 8 && i < got_q.size(); i++)
            check_eq("fair_order", 64'(got_q[i]), 64'(exp_q[i]));
        wait_idle();

        // response backpressure on core 2
        do_reset();
        got_q.delete();
        resp_ready = 4'b1011;
        for (int k = 0; k < NC; k++)
            drive_req(k, 32'h4100_0000 + 32'(k), 32'h3FC0_0000, 3'd1);
        for (int c = 0; c < 20 && !resp_valid[2]; c++) tick();
        for (int i = 0; i < 10; i++) begin
            check_eq("bp_valid", 64'(resp_valid[2]), 64'd1);
            check_eq("bp_stable", 64'(resp_res[2]), 64'(32'h4100_0002 ^ 32'h3FC0_0000 ^ 32'h3F80_0000));
            tick();
        end
        check_eq("bp_no_regrant", 64'(count_grants(2)), 64'd1);
        check_eq("bp_others_run", 64'(count_grants(0) >= 3 && count_grants(3) >= 3), 64'd1);
        resp_ready = '1;
        for (int c = 0; c < 20 && count_grants(2) < 2; c++) tick();
        check_eq("bp_regrant", 64'(count_grants(2) >= 2), 64'd1);
        req_valid = '0;
        wait_idle();

        // unit stall
        do_reset();
        resp_ready = '0;
        drive_req(0, 32'h3F80_0000, 32'h4080_0000, 3'd0);
        #1;
        check_eq("stall_first", 64'(req_ready), 64'b0001);
        tick();
        req_valid  = '0;
        unit_ready = 1'b0;
        for (int k = 1; k < NC; k++) drive_req(k, 32'h3F80_0000, 32'h4000_0000, 3'd0);
        #1;
        for (int i = 0; i < 5; i++) begin
            check_eq("stall_ready", 64'(req_ready), 64'd0);
            check_eq("stall_ptr", 64'(rr_ptr), 64'd1);
            tick();
        end
        check_eq("stall_capture", 64'(resp_valid), 64'b0001);
        unit_ready = 1'b1;
        #1;
        check_eq("stall_resume", 64'(req_ready), 64'b0010);
        tick();
        check_eq("stall_ptr_adv", 64'(rr_ptr), 64'd2);
        check_eq("stall_tag", 64'(tag), 64'd1);
        resp_ready = '1;
        req_valid  = '0;
        wait_idle();

        // protocol error: result for an idle slot
        do_reset();
        inj_tag = 2'd3;
        inj_v   = 1'b1;
        tick();
        inj_v = 1'b0;
        check_eq("err_set", 64'(err), 64'd1);
        check_eq("err_no_resp", 64'(resp_valid), 64'd0);
        check_eq("err_slots", 64'(slot_state), 64'd0);
        tick();
        tick();
        check_eq("err_sticky", 64'(err), 64'd1);
        rst = 1'b1;
        tick();
        check_eq("err_cleared", 64'(err), 64'd0);
        rst = 1'b0;

        // reset with two ops in flight, L=3
        do_reset();
        unit_lat = 3;
        drive_req(0, 32'h4000_0000, 32'h4000_0000, 3'd0);
        drive_req(1, 32'h4040_0000, 32'h4000_0000, 3'd0);
        tick();
        tick();
        req_valid = '0;
        check_eq("mid_busy", 64'(busy), 64'd1);
        rst = 1'b1;
        tick();
        check_eq("mid_en", 64'(en), 64'd0);
        check_eq("mid_opa", 64'(opa), 64'd0);
        check_eq("mid_busy_clr", 64'(busy), 64'd0);
        check_eq("mid_resp", 64'(resp_valid), 64'd0);
        check_eq("mid_ptr", 64'(rr_ptr), 64'd0);
        req_valid = 4'b0011;
        #1;
        check_eq("mid_ready_rst", 64'(req_ready), 64'd0);
        req_valid = '0;
        tick();
        tick();
        rst = 1'b0;
        resp_ready = '0;
        drive_req(0, 32'h4040_0000, 32'h3F80_0000, 3'd3);
        tick();
        req_valid = '0;
        lat = 1;
        while (!resp_valid[0] && lat < 20) begin
            tick();
            lat++;
        end
        check_eq("lat3_latency", 64'(lat), 64'd5);
        check_eq("lat3_res", 64'(resp_res[0]), 64'h4040_0000);
        check_eq("lat3_status", 64'(resp_status[0]), 64'h13);
        resp_ready = '1;
        tick();
        wait_idle();
        check_eq("lat3_no_err", 64'(err), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
